// File: rtl/mips16_muldiv_ctrl_pkg.sv
// Shared definitions for the mips16 multiply/divide sequencer: width, op codes, FSM states.
package mips16_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StIter,
    StFix,
    StDone
  } muldiv_state_t;

  localparam logic [WIDTH-1:0] DIV0_QUOT = '1;

  function automatic logic op_is_div(logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mips16_muldiv_ctrl_if.sv
// Decoder-side request, HI/LO access and status signals of the multiply/divide sequencer.
interface mips16_muldiv_ctrl_if;
  import mips16_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       hi_lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             hi_lo_sl;
  logic [WIDTH-1:0] read_data;
  logic             instr_stall_sl;
  logic             ready;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, hi_lo_we, wr_data, hi_lo_sl,
    input  read_data, instr_stall_sl, ready, busy, div_by_zero
  );

  modport slave (
    input  start, op, a, b, hi_lo_we, wr_data, hi_lo_sl,
    output read_data, instr_stall_sl, ready, busy, div_by_zero
  );

endinterface

// File: rtl/mips16_muldiv_step.sv
// One combinational iteration: shift-add multiply on {acc, mplier} or restoring divide on
// {rem, quot}.
module mips16_muldiv_step
  import mips16_pkg::*;
(
  input  logic [2*WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] work_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum    = {1'b0, work_i[2*WIDTH-1:WIDTH]} + (work_i[0] ? {1'b0, operand_i} : '0);
    // Shifted remainder can need WIDTH+1 bits; bit WIDTH of the difference is the borrow.
    trial  = work_i[2*WIDTH-1:WIDTH-1] - {1'b0, operand_i};
    work_o = {sum, work_i[WIDTH-1:1]};
    if (div_i) begin
      if (!trial[WIDTH]) begin
        work_o = {trial[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
      end else begin
        work_o = {work_i[2*WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mips16_muldiv_ctrl.sv
// Iterative mult/multu/div/divu sequencer owning HI/LO; stalls fetch while an op is in flight.
module mips16_muldiv_ctrl
  import mips16_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  mips16_muldiv_ctrl_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] work_q, work_d, step_work;
  logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  mips16_muldiv_step u_step (
    .work_i    (work_q),
    .operand_i (opnd_q),
    .div_i     (op_is_div(op_q)),
    .work_o    (step_work)
  );

  always_comb begin
    a_neg    = op_is_signed(op_q) & a_q[WIDTH-1];
    b_neg    = op_is_signed(op_q) & b_q[WIDTH-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    prod_fix = neg_q ? -work_q : work_q;
    quot_fix = neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    work_d  = work_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.hi_lo_we[1]) hi_d = bus.wr_data;
        if (bus.hi_lo_we[0]) lo_d = bus.wr_data;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          dz_d    = 1'b0;
          state_d = StPrep;
        end
      end
      StPrep: begin
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
        cnt_d  = '0;
        if (op_is_div(op_q)) begin
          work_d = {{WIDTH{1'b0}}, a_mag};
          opnd_d = b_mag;
        end else begin
          work_d = {{WIDTH{1'b0}}, b_mag};
          opnd_d = a_mag;
        end
        if (op_is_div(op_q) && (b_q == '0)) begin
          dz_d    = 1'b1;
          lo_d    = DIV0_QUOT;
          hi_d    = a_q;
          state_d = StDone;
        end else begin
          state_d = StIter;
        end
      end
      StIter: begin
        work_d = step_work;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (op_is_div(op_q)) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      work_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      work_q  <= work_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.read_data      = bus.hi_lo_sl ? hi_q : lo_q;
  assign bus.ready          = (state_q == StDone);
  assign bus.busy           = (state_q != StIdle);
  assign bus.div_by_zero    = dz_q;
  // Combinational so the issuing instruction is held in the very cycle start is seen.
  assign bus.instr_stall_sl = ((state_q == StIdle) & bus.start) | (state_q == StPrep) |
                              (state_q == StIter) | (state_q == StFix);

endmodule
